// File: rtl/sum_display_driver.sv
// sum_display_driver: captures a 5-bit adder result, converts it to BCD by sequential double-dabble,
// and drives a time-multiplexed 4-digit common-anode seven-segment display.
module sum_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  input  logic       load,
  output logic       ready,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  typedef enum logic {IDLE, CONV} state_t;
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  state_t        state_q;
  logic [4:0]    bin_q;
  logic [7:0]    bcd_q, disp_q;
  logic [2:0]    iter_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q, an_d, ones_adj, tens_adj;
  logic [6:0]    seg_q, seg_d;
  logic [12:0]   shift_d;
  logic          wrap;
  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0: pattern = 7'b1000000;
      4'd1: pattern = 7'b1111001;
      4'd2: pattern = 7'b0100100;
      4'd3: pattern = 7'b0110000;
      4'd4: pattern = 7'b0011001;
      4'd5: pattern = 7'b0010010;
      4'd6: pattern = 7'b0000010;
      4'd7: pattern = 7'b1111000;
      4'd8: pattern = 7'b0000000;
      4'd9: pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
  endfunction
  always_comb begin
    ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shift_d  = {tens_adj, ones_adj, bin_q} << 1;
    wrap     = cnt_q == CW'(REFRESH_DIV - 1);
    // a zero tens digit is blanked rather than shown as a leading zero
    an_d     = (idx_q == 2'd0) ? 4'b1110 :
               (idx_q == 2'd1 && disp_q[7:4] != 4'd0) ? 4'b1101 : 4'b1111;
    seg_d    = (an_d == 4'b1110) ? pattern(disp_q[3:0]) :
               (an_d == 4'b1101) ? pattern(disp_q[7:4]) : 7'b1111111;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      idx_q <= idx_q + 2'(wrap);
      an_q  <= an_d;
      seg_q <= seg_d;
      if (state_q == IDLE) begin
        if (load) begin
          bin_q   <= {cout_in, sum_in};
          bcd_q   <= '0;
          iter_q  <= '0;
          state_q <= CONV;
        end
      end else begin
        {bcd_q, bin_q} <= shift_d;
        iter_q         <= iter_q + 3'd1;
        if (iter_q == 3'd4) begin
          disp_q  <= shift_d[12:5];
          state_q <= IDLE;
        end
      end
    end
  end
  assign ready = state_q == IDLE;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;
endmodule

// File: tb/tb_sum_display_driver.sv
// tb_sum_display_driver: directed checks of capture, BCD conversion and display scan with REFRESH_DIV=4.
module tb_sum_display_driver;
  logic       clk = 1'b0, rst_n = 1'b0, cout_in = 1'b0, load = 1'b0;
  logic [3:0] sum_in = '0;
  logic       ready, dp;
  logic [3:0] an;
  logic [6:0] seg;
  int         checks = 0, errors = 0, n;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  sum_display_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .cout_in(cout_in), .load(load),
    .ready(ready), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // edges since reset release; the slot shown lags the digit index by one edge
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic scan(input int v);
    int tens = v / 10, ones = v % 10, slot;
    logic [3:0] ea;
    logic [6:0] es;
    repeat (16) begin
      @(negedge clk);
      slot = (n == 0) ? 0 : ((n - 1) / 4) % 4;
      ea = (slot == 0) ? 4'b1110 : (slot == 1 && tens != 0) ? 4'b1101 : 4'b1111;
      es = (slot == 0) ? pat[ones] : (ea == 4'b1101) ? pat[tens] : 7'b1111111;
      chk($sformatf("an v=%0d slot=%0d", v, slot), 32'(an), 32'(ea));
      chk($sformatf("seg v=%0d slot=%0d", v, slot), 32'(seg), 32'(es));
    end
    chk("dp", 32'(dp), 32'd1);
  endtask

  task automatic do_load(input int v);
    int low = 0;
    {cout_in, sum_in} = 5'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (!ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    chk($sformatf("ready_low v=%0d", v), 32'(low), 32'd5);
    @(negedge clk);
  endtask

  initial begin
    int low;
    // reset asserted mid-scan takes effect without a clock edge
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_dp", 32'(dp), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    scan(0);

    do_load(31);
    scan(31);
    do_load(9);
    scan(9);
    do_load(10);
    scan(10);

    // load held during conversion is dropped
    {cout_in, sum_in} = 5'd5;
    load = 1'b1;
    @(negedge clk);
    chk("conv_busy", 32'(ready), 32'd0);
    {cout_in, sum_in} = 5'd22;
    repeat (3) @(negedge clk);
    load = 1'b0;
    wait_ready();
    @(negedge clk);
    scan(5);
    chk("no_queue", 32'(ready), 32'd1);

    // load still high at the first ready edge is accepted
    {cout_in, sum_in} = 5'd5;
    load = 1'b1;
    @(negedge clk);
    {cout_in, sum_in} = 5'd22;
    low = 0;
    while (!ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    chk("ready_low held", 32'(low), 32'd5);
    @(negedge clk);
    load = 1'b0;
    chk("recapture", 32'(ready), 32'd0);
    wait_ready();
    @(negedge clk);
    scan(22);

    // reset during conversion aborts it
    {cout_in, sum_in} = 5'd30;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_an", 32'(an), 32'b1110);
    chk("abort_seg", 32'(seg), 32'b1000000);
    chk("abort_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    scan(0);

    for (int v = 0; v < 32; v++) begin
      do_load(v);
      scan(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sum_display_driver.md
# sum_display_driver

Downstream consumer of the 4-bit ripple adder result. It captures the 5-bit sum `{cout, S}` (0..31) on a load strobe and converts it to two BCD digits with a sequential 5-iteration double-dabble. It then drives the Basys3 4-digit common-anode seven-segment display with a time-multiplexed scan. It sits between the adder's `S`/`cout` outputs and the board's `an`/`seg`/`dp` pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Legal range is ≥2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sum_in`  in  4  adder sum bits `S[3:0]`.
- `cout_in`  in  1  adder carry-out; forms bit 4 of the captured value.
- `load`  in  1  capture request; sampled only when `ready`=1.
- `ready`  out  1  high when idle and able to accept `load`.
- `an`  out  4  digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  cathodes, active-low, ordered `{g,f,e,d,c,b,a}` as `seg[6:0]`.
- `dp`  out  1  decimal point, active-low; constant 1 (off).

## Operation
- **Capture.** `load`=1 with `ready`=1 latches `v = {cout_in, sum_in}` into a 5-bit shift register, clears an 8-bit BCD register, and moves IDLE→CONV.
- **States.**
  - IDLE (`ready`=1).
  - CONV (`ready`=0) for exactly 5 cycles, counted by a 3-bit iteration counter 0..4.
  - After the 5th iteration: copy BCD to the display register `{tens[3:0], ones[3:0]}`, return to IDLE.
- **Double-dabble iteration.**
  - If the `ones` nibble is ≥5, add 3 to it; same test and add for the `tens` nibble.
  - Then shift `{bcd, bin}` left by 1.
  - The result is exact for 0..31: `tens` ∈ 0..3, `ones` ∈ 0..9.
- **Ignored and held values.**
  - `load` during CONV is ignored; it is not queued.
  - The display keeps showing the previous result until the copy happens.
- **Refresh counter.**
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At each wrap, the 2-bit digit index advances 0→1→2→3→0.
  - The counter runs in every state and is independent of conversion.
- **Digit slot output.**
  - Slot 0: `an`=4'b1110, `seg`=pattern(`ones`).
  - Slot 1: if `tens`≠0, `an`=4'b1101 and `seg`=pattern(`tens`); if `tens`=0, leading-zero blank with `an`=4'b1111 and `seg`=7'b1111111.
  - Slots 2,3: always blank, `an`=4'b1111, `seg`=7'b1111111.
- **Patterns `{g..a}`, active-low.**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble is unreachable; it must decode to blank.
- **Registered outputs.** `an` and `seg` are registered, updated one cycle after the index or display register changes, so they are glitch-free.

## Timing
- **Reset (`rst_n`=0, asynchronous).**
  - State IDLE, `ready`=1.
  - Display register 0; refresh counter and digit index 0.
  - `an`=4'b1110, `seg`=7'b1000000, `dp`=1.
- **Conversion latency.**
  - `load` sampled high at edge k → `ready`=0 after edge k.
  - Iterations run on edges k+1..k+5.
  - The display register takes the new value and `ready`=1 after edge k+5.
  - `load` may therefore be accepted again at edge k+6.
- **Simultaneous events.** `load` on the same edge that CONV completes is ignored, because `ready` was 0 during that cycle.
- **Reset mid-CONV.** Aborts immediately; the display returns to 0. No partial result is ever shown.
- **Refresh timing.**
  - Each digit is active for REFRESH_DIV cycles.
  - A full scan takes 4·REFRESH_DIV cycles.
  - `an`/`seg` change one cycle after the counter wraps.
- **Input stability.** `sum_in`/`cout_in` need only be stable at the capture edge; later changes have no effect.

## Test plan
Run all scenarios with REFRESH_DIV=4.
1. **Reset.** Assert `rst_n`=0 mid-scan → `an`=1110, `seg`=1000000, `ready`=1 immediately, without waiting for a clock edge.
2. **Full range.** `cout_in`=1, `sum_in`=4'hF (31), pulse `load` → `ready` low for exactly 5 cycles. Scan then shows slot 0 `seg`=1111001 ("1") and slot 1 `seg`=0110000 ("3"); slots 2,3 have `an`=1111.
3. **Leading-zero blank.** `load` with value 9 → slot 0 `seg`=0010000 and slot 1 `an`=1111. Then `load` with value 10 → slot 1 `an`=1101, `seg`=1111001; slot 0 `seg`=1000000.
4. **Load during CONV.** `load` value 5, then hold `load`=1 with value 22 for 3 cycles → display shows "5". Value 22 is captured only if `load` is still high at the first `ready`=1 edge.
5. **Reset during CONV.** `load` value 30, assert `rst_n`=0 at iteration 3 → display 0, `ready`=1, and "30" never appears.
6. **Exhaustive sweep.** Values 0..31 back-to-back → the displayed `tens`/`ones` match decimal `v` on every value, and the scan order 1110→(1101|1111)→1111→1111 repeats every 16 cycles.
